nios_led_fader: RTL

NIOS_LED_FADER -- requirements
Module: nios_led_fader

---
 rtl/nios_led_fader.sv | 133 +++++++++++++
 1 files changed

// File: rtl/nios_led_fader.sv
`default_nettype none
// ============================================================================
// Module   : nios_led_fader
// Brief    : Four-channel LED PWM fader with soft on/off ramps driven by a PIO.
// Revision : 1.0 - initial release
// ============================================================================
module nios_led_fader #(
    parameter int CLK_DIV  = 50,
    parameter int PWM_W    = 8,
    parameter int RAMP_DIV = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] led_in,
    output logic [3:0] led_out,
    output logic [3:0] led_busy
);

    localparam int C_PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int C_RAMP_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [C_PRESC_W-1:0] C_PRESC_MAX = C_PRESC_W'(CLK_DIV - 1);
    localparam logic [C_RAMP_W-1:0]  C_RAMP_MAX  = C_RAMP_W'(RAMP_DIV - 1);
    localparam logic [PWM_W-1:0]     C_DMAX      = {PWM_W{1'b1}};

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_UP   = 2'd1,
        ST_ON   = 2'd2,
        ST_DOWN = 2'd3
    } state_t;

    logic [3:0]           req_q;
    logic [C_PRESC_W-1:0] presc_q;
    logic [PWM_W-1:0]     pwm_cnt_q;
    logic [C_RAMP_W-1:0]  ramp_q;

    logic w_tick;
    logic w_period_end;
    logic w_step;

    assign w_tick       = (presc_q == C_PRESC_MAX);
    assign w_period_end = w_tick && (pwm_cnt_q == C_DMAX);
    assign w_step       = w_period_end && (ramp_q == C_RAMP_MAX);

    // Shared timebase runs freely; LED activity never disturbs its phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q     <= '0;
            presc_q   <= '0;
            pwm_cnt_q <= '0;
            ramp_q    <= '0;
        end else begin
            req_q   <= led_in;
            presc_q <= w_tick ? '0 : presc_q + C_PRESC_W'(1);
            if (w_tick) begin
                pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
            end
            if (w_period_end) begin
                ramp_q <= w_step ? '0 : ramp_q + C_RAMP_W'(1);
            end
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_led
        state_t           state_q;
        logic [PWM_W-1:0] duty_q;
        logic             out_q;
        logic             busy_q;

        // Outputs reflect the state held before this edge, giving one extra
        // cycle of latency after the FSM moves.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= ST_OFF;
                duty_q  <= '0;
                out_q   <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                out_q  <= (state_q == ST_ON) ||
                          (((state_q == ST_UP) || (state_q == ST_DOWN)) && (pwm_cnt_q < duty_q));
                busy_q <= (state_q == ST_UP) || (state_q == ST_DOWN);
                case (state_q)
                    ST_OFF: begin
                        duty_q <= '0;
                        if (req_q[i]) begin
                            state_q <= ST_UP;
                        end
                    end
                    ST_UP: begin
                        if (!req_q[i]) begin
                            state_q <= ST_DOWN;
                        end else if (w_step) begin
                            if (duty_q >= C_DMAX - PWM_W'(1)) begin
                                state_q <= ST_ON;
                                duty_q  <= C_DMAX;
                            end else begin
                                duty_q <= duty_q + PWM_W'(1);
                            end
                        end
                    end
                    ST_ON: begin
                        duty_q <= C_DMAX;
                        if (!req_q[i]) begin
                            state_q <= ST_DOWN;
                        end
                    end
                    ST_DOWN: begin
                        if (req_q[i]) begin
                            state_q <= ST_UP;
                        end else if (w_step) begin
                            // A reversal straight out of OFF can leave duty at 0 here.
                            if (duty_q <= PWM_W'(1)) begin
                                state_q <= ST_OFF;
                                duty_q  <= '0;
                            end else begin
                                duty_q <= duty_q - PWM_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_OFF;
                        duty_q  <= '0;
                    end
                endcase
            end
        end

        assign led_out[i]  = out_q;
        assign led_busy[i] = busy_q;
    end

endmodule
`default_nettype wire
